// File: rtl/instr_mem_loader.sv
// Program loader: accepts 32-bit instruction words over valid/ready and writes
// each one as four little-endian byte writes, STRIDE bytes apart from a base.
module instr_mem_loader #(
  parameter int SIZE   = 256,
  parameter int STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] start_adr,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        mem_we,
  output logic [63:0] mem_adr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [63:0] LAST_OK = 64'(SIZE - 4);
  localparam logic [63:0] STEP    = 64'(STRIDE);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic [63:0] cur_adr;
  logic [31:0] word_q;
  logic        last_q;
  logic        error_q;
  logic [15:0] count_q;
  logic        accept;
  logic        fits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The fit check is made against the word's base address before any byte
  // goes out, so an overflowing word is dropped whole.
  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_adr    = 64'd0;
    mem_wdata  = 8'd0;
    done       = 1'b0;
    accept     = 1'b0;
    fits       = (cur_adr <= LAST_OK);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (word_valid) begin
          accept    = 1'b1;
          state_nxt = fits ? S_WRITE : S_ERR;
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_adr   = cur_adr + {62'd0, idx};
        mem_wdata = word_q[{idx, 3'b000} +: 8];
        if (idx == 2'd3) begin
          state_nxt = last_q ? S_DONE : S_WAIT;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    error        = error_q;
    words_loaded = count_q;
  end

  // Error is raised on the accepting edge so it is visible throughout ERR and
  // stays sticky in IDLE until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 2'd0;
      cur_adr <= 64'd0;
      word_q  <= 32'd0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_adr <= start_adr;
            count_q <= 16'd0;
            error_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (accept) begin
            word_q <= word_data;
            last_q <= word_last;
            idx    <= 2'd0;
            if (!fits) begin
              error_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            cur_adr <= cur_adr + STEP;
            if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed sessions from the test plan plus random
// sessions, checked against an address/byte model and a memory image.
module tb_instr_mem_loader;

  localparam int SIZE   = 256;
  localparam int STRIDE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] start_adr;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_last;
  logic        mem_we;
  logic [63:0] mem_adr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  int we_count = 0;
  int oob_count = 0;
  int mdl_we = 0;
  int mdl_k = 0;
  logic [63:0] mdl_base = 64'd0;
  logic [7:0]  dut_mem   [SIZE] = '{default: 8'h00};
  logic [7:0]  model_mem [SIZE] = '{default: 8'h00};
  logic [31:0] prog [4] = '{32'h8B1F03E5, 32'hF84000A4, 32'h8B040086, 32'hF80010A6};

  instr_mem_loader #(.SIZE(SIZE), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .start_adr(start_adr),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .word_last(word_last), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Passive memory: records every byte the loader writes.
  always @(posedge clk) begin
    if (mem_we) begin
      we_count <= we_count + 1;
      if (mem_adr < 64'(SIZE)) dut_mem[mem_adr[7:0]] <= mem_wdata;
      else oob_count <= oob_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the first WAIT cycle.
  task automatic startSession(input logic [63:0] adr);
    start = 1'b1;
    start_adr = adr;
    @(negedge clk);
    start = 1'b0;
    start_adr = {$urandom, $urandom};
    mdl_base = adr;
    mdl_k = 0;
    checkOutput("start_ready", word_ready, 1);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_err_clr", error, 0);
    checkOutput("start_wl_clr", words_loaded, 0);
    checkOutput("start_we", mem_we, 0);
  endtask

  // Called at a negedge in WAIT. Sends one word and checks every following cycle.
  task automatic applyStimulus(input logic [31:0] data, input logic last, input int gap,
                               input bit hold, input bit poke, output bit ended);
    logic [63:0] ea;
    ea = mdl_base + 64'(mdl_k) * 64'(STRIDE);
    ended = 1'b0;
    word_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      checkOutput("ready_wait", word_ready, 1);
    end
    word_valid = 1'b1;
    word_data = data;
    word_last = last;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      word_data = $urandom;
      word_last = 1'($urandom);
    end else begin
      word_valid = 1'b0;
    end
    if (ea > 64'(SIZE - 4)) begin
      word_valid = 1'b0;
      checkOutput("ovf_error", error, 1);
      checkOutput("ovf_we", mem_we, 0);
      checkOutput("ovf_busy", busy, 0);
      @(negedge clk);
      checkOutput("ovf_idle_err", error, 1);
      checkOutput("ovf_idle_ready", word_ready, 0);
      checkOutput("ovf_idle_busy", busy, 0);
      checkOutput("ovf_we_count", we_count, mdl_we);
      ended = 1'b1;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      if (poke) start = (b == 1);
      if (poke && b == 1) start_adr = 64'hC0;
      checkOutput("we", mem_we, 1);
      checkOutput("adr", mem_adr, ea + 64'(b));
      checkOutput("wdata", mem_wdata, data[8*b +: 8]);
      checkOutput("ready_low", word_ready, 0);
      checkOutput("busy_write", busy, 1);
      model_mem[8'(ea + 64'(b))] = data[8*b +: 8];
    end
    @(negedge clk);
    start = 1'b0;
    mdl_k++;
    mdl_we += 4;
    checkOutput("words_loaded", words_loaded, 64'(mdl_k));
    checkOutput("we_count", we_count, mdl_we);
    if (last) begin
      checkOutput("done_pulse", done, 1);
      checkOutput("done_busy", busy, 0);
      @(negedge clk);
      checkOutput("done_clear", done, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_ready", word_ready, 0);
      ended = 1'b1;
    end else begin
      checkOutput("ready_next", word_ready, 1);
      checkOutput("no_done", done, 0);
    end
  endtask

  initial begin
    bit ended;
    int n;
    int mism;
    logic [63:0] ea;
    rst = 1'b1;
    start = 1'b0;
    start_adr = 64'd0;
    word_valid = 1'b0;
    word_data = 32'd0;
    word_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", word_ready, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_adr", mem_adr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_wl", words_loaded, 0);

    // Single word at address 0.
    startSession(64'd0);
    applyStimulus(prog[0], 1'b1, 0, 1'b0, 1'b0, ended);

    // Four words at stride 16 from base 0.
    @(negedge clk);
    startSession(64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(prog[i], i == 3, 1, 1'b0, 1'b0, ended);

    // Continuous valid, three words from base 64.
    @(negedge clk);
    startSession(64'd64);
    for (int i = 0; i < 3; i++) applyStimulus($urandom, i == 2, 0, i != 2, 1'b0, ended);

    // Overflow then recovery on the next start.
    @(negedge clk);
    startSession(64'd253);
    applyStimulus(32'hDEADBEEF, 1'b1, 0, 1'b0, 1'b0, ended);
    repeat (2) begin
      @(negedge clk);
      checkOutput("err_sticky", error, 1);
    end
    startSession(64'd200);
    applyStimulus($urandom, 1'b1, 0, 1'b0, 1'b0, ended);

    // Reset after byte 1 of a word.
    @(negedge clk);
    startSession(64'd128);
    applyStimulus($urandom, 1'b0, 0, 1'b0, 1'b0, ended);
    ea = mdl_base + 64'(STRIDE);
    word_valid = 1'b1;
    word_data = 32'hA1B2C3D4;
    word_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    word_valid = 1'b0;
    checkOutput("rmw_b0_adr", mem_adr, ea);
    model_mem[ea[7:0]] = 8'hD4;
    @(negedge clk);
    checkOutput("rmw_b1_adr", mem_adr, ea + 64'd1);
    checkOutput("rmw_b1_data", mem_wdata, 8'hC3);
    model_mem[8'(ea + 64'd1)] = 8'hC3;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_we += 2;
    checkOutput("rmw_we", mem_we, 0);
    checkOutput("rmw_busy", busy, 0);
    checkOutput("rmw_wl", words_loaded, 0);
    checkOutput("rmw_ready", word_ready, 0);
    checkOutput("rmw_we_count", we_count, mdl_we);
    startSession(64'd8);
    applyStimulus($urandom, 1'b1, 0, 1'b0, 1'b0, ended);

    // Start pulsed during WRITE must be ignored.
    @(negedge clk);
    startSession(64'd4);
    applyStimulus($urandom, 1'b0, 0, 1'b0, 1'b1, ended);
    applyStimulus($urandom, 1'b1, 0, 1'b0, 1'b0, ended);

    // Random sessions; some run off the end of memory.
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      n = $urandom_range(1, 4);
      startSession(64'($urandom_range(0, 260)));
      for (int i = 0; i < n; i++) begin
        applyStimulus($urandom, i == n - 1, $urandom_range(0, 2),
                      (i != n - 1) && ($urandom_range(0, 1) == 1), 1'b0, ended);
        if (ended) break;
      end
    end

    @(negedge clk);
    mism = 0;
    for (int a = 0; a < SIZE; a++) if (dut_mem[a] !== model_mem[a]) mism++;
    checkOutput("mem_image", 64'(mism), 0);
    checkOutput("oob_writes", 64'(oob_count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Program loader that fills the byte-wide instruction memory from a 32-bit word stream. It accepts instruction words over a valid/ready handshake and writes each word as four little-endian byte writes, byte 0 at the lowest address. Consecutive words are placed `STRIDE` bytes apart starting at a programmable base. It sits between the test/boot source and the instruction memory's write port, ahead of instruction fetch.

## Interface

Parameters:
- `SIZE`, 256: instruction memory depth in bytes.
- `STRIDE`, 4: byte distance between consecutive words. Must be ≥ 4.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a load session; sampled only in IDLE.
- `start_adr`  in  64  byte address of the first word; sampled with `start`.
- `word_valid`  in  1  source has a word.
- `word_ready`  out  1  loader can accept a word.
- `word_data`  in  32  instruction word.
- `word_last`  in  1  marks the final word of the session; sampled with the word.
- `mem_we`  out  1  byte write enable to instruction memory.
- `mem_adr`  out  64  byte write address.
- `mem_wdata`  out  8  write byte.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse after the last byte of a session is written.
- `error`  out  1  sticky overflow flag.
- `words_loaded`  out  16  words fully written in the current or last session.

## Operation

- States are IDLE, WAIT, WRITE, DONE and ERR. Byte index `idx` is 2 bits. Current address `cur_adr` is 64 bits. The captured word and `last` flag are held in registers.
- **IDLE**
  - `word_ready`=0 and `busy`=0.
  - When `start`=1: `cur_adr`←`start_adr`, `words_loaded`←0, `error`←0, go to WAIT.
- **WAIT**
  - `word_ready`=1 and `busy`=1.
  - On `word_valid`&`word_ready`, capture `word_data` and `word_last`.
  - If `cur_adr` > `SIZE`-4, the word does not fit: go to ERR with no writes.
  - Otherwise go to WRITE with `idx`=0.
- **WRITE**
  - `word_ready`=0, `busy`=1, `mem_we`=1.
  - `mem_adr`=`cur_adr`+`idx`; `mem_wdata`=word[8·idx+7 : 8·idx].
  - `idx` increments each cycle.
  - After the `idx`=3 write:
    - `words_loaded`+1 and `cur_adr`+`STRIDE`.
    - Go to DONE if the captured `last`=1, else to WAIT.
- **DONE**
  - `done`=1 for exactly one cycle, `busy`=0.
  - Go to IDLE.
- **ERR**
  - `error`←1, `busy`=0.
  - Go to IDLE. `error` stays high until the next accepted `start` or `rst`.
- Outputs are Moore decodes of registered state. When `mem_we`=0, `mem_adr` and `mem_wdata` are driven 0.
- `start` outside IDLE is ignored. `word_valid` outside WAIT is ignored and nothing is consumed.
- Address arithmetic is unsigned 64-bit. The overflow check precedes every write, so no write ever targets an address ≥ `SIZE`.
- `words_loaded` saturates at 0xFFFF.

## Timing

- Reset values:
  - `word_ready`, `mem_we`, `mem_adr`, `mem_wdata`, `busy`, `done`, `error`, `words_loaded` all 0.
  - State IDLE, `idx`=0, `cur_adr`=0.
- `start` sampled at edge E puts the loader in WAIT. `word_ready`=1 in the cycle after E.
- Word accepted at edge A:
  - Bytes 0..3 are written in cycles A+1..A+4, with `mem_we` high for exactly 4 consecutive cycles.
  - Next `word_ready` is in cycle A+5, or `done` is in cycle A+5 if the word was last.
- Sustained throughput is one word per 5 cycles. Total session length for N words is 1 + 5N + 1 cycles from `start` to `done`.
- Overflow word accepted at A: `error`=1 from cycle A+1; IDLE at A+2; no `mem_we` pulse.
- `rst` at any edge takes effect at that edge:
  - All outputs return to reset values in the following cycle.
  - A partially written word is abandoned. Bytes already written remain in memory.

## Test plan

- **Single word.** `start_adr`=0, one word 0x8B1F03E5 with `last`=1. Required:
  - Writes (0,E5), (1,03), (2,1F), (3,8B) on consecutive cycles.
  - `done` pulse one cycle later; `words_loaded`=1.
- **Four words, STRIDE=16.** Words 0x8B1F03E5, 0xF84000A4, 0x8B040086, 0xF80010A6, last on the fourth. Required:
  - Byte writes at 0–3, 16–19, 32–35, 48–51 with matching little-endian bytes.
  - `words_loaded`=4.
- **Continuous valid.** `word_valid` held high for 3 words. Required:
  - `word_ready` high exactly one cycle in every 5.
  - Each word is written exactly once with no duplication.
- **Overflow.** `SIZE`=256, `start_adr`=253, one word. Required:
  - No `mem_we`; `error`=1 stays high in IDLE.
  - The next `start` clears `error`.
- **Reset mid-word.** Assert `rst` on the edge after byte 1 is written. Required:
  - `mem_we`=0 and `busy`=0 in the next cycle; `words_loaded`=0.
  - `start` works normally afterwards.
- **Start while busy.** Pulse `start` with a different `start_adr` during WRITE. Required:
  - Ignored; subsequent addresses continue from the original base.
